// File: rtl/pci_rr_arbiter.sv
// pci_rr_arbiter: central round-robin REQ#/GNT# arbiter for a shared PCI-style bus.
// Tracks bus ownership from the global FRAME#/IRDY# pair. At most one grant is
// active at any time, and every hand-over passes through an all-ones gnt_n cycle.
// Grants that go unused for GNT_TIMEOUT cycles are revoked.
// Optional feature: define PCI_ARB_PARK_EN to park the grant on PARK_MASTER
// whenever nobody requests. When the macro is undefined, no PARK state exists.
module pci_rr_arbiter #(
  parameter int N_MASTERS   = 8,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_MASTER = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_valid,
  output logic                         timeout_pulse
);

  localparam int PW = $clog2(N_MASTERS);
  localparam int TW = $clog2(GNT_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(GNT_TIMEOUT - 1);

  // Elaboration-time sanity check on the configuration
  generate
    if (N_MASTERS < 2 || N_MASTERS > 16 || GNT_TIMEOUT < 2 ||
        PARK_MASTER < 0 || PARK_MASTER >= N_MASTERS) begin : g_bad_params
      $error("pci_rr_arbiter: parameter out of range");
    end
  endgenerate

`ifdef PCI_ARB_PARK_EN
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_BUSY, S_TURN, S_PARK} state_e;
  localparam logic [N_MASTERS-1:0] PARK_OH  = N_MASTERS'(1) << PARK_MASTER;
  localparam logic [PW-1:0]        PARK_IDX = PW'(PARK_MASTER);
`else
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_TURN} state_e;
`endif

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [N_MASTERS-1:0]   gnt_n_q, gnt_n_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic                   owner_valid_q, owner_valid_d;
  logic                   timeout_pulse_q, timeout_pulse_d;

  logic                   bus_idle;
  logic [PW-1:0]          win_idx;
  logic                   win_any;
  logic [N_MASTERS-1:0]   win_oh;

  assign bus_idle = frame_n & irdy_n;

  // Round-robin search: the first requester after ptr, wrapping modulo N_MASTERS
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    win_idx = ptr_q;
    win_any = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx  = (int'(ptr_q) + k) % N_MASTERS;
      cand = PW'(idx);
      if (!win_any && !req_n[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
    win_oh = N_MASTERS'(1) << win_idx;
  end

  // Next-state and registered-output logic for the ownership FSM
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    timer_d         = timer_q;
    gnt_n_d         = gnt_n_q;
    owner_d         = owner_q;
    owner_valid_d   = owner_valid_q;
    timeout_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_n_d = '1;
        if (!frame_n) begin
          // Another agent is already on the bus, so wait for it to finish
          state_d = S_TURN;
        end else if (win_any) begin
          gnt_n_d = ~win_oh;
          owner_d = win_idx;
          timer_d = '0;
          state_d = S_GRANT;
        end
`ifdef PCI_ARB_PARK_EN
        else begin
          gnt_n_d = ~PARK_OH;
          owner_d = PARK_IDX;
          state_d = S_PARK;
        end
`endif
      end

      S_GRANT: begin
        if (!frame_n) begin
          // The grantee has started, so rotate priority past it now
          owner_valid_d = 1'b1;
          ptr_d         = owner_q;
          state_d       = S_BUSY;
        end else if (req_n[owner_q]) begin
          gnt_n_d = '1;
          state_d = S_IDLE;
        end else if (timer_q == T_LAST) begin
          // The master sat on its grant, so it loses its turn
          gnt_n_d         = '1;
          timeout_pulse_d = 1'b1;
          ptr_d           = owner_q;
          state_d         = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_BUSY: begin
        // A request dropped mid-transaction is ignored; FRAME# alone ends it
        if (frame_n) begin
          gnt_n_d       = '1;
          owner_valid_d = 1'b0;
          state_d       = S_TURN;
        end
      end

      S_TURN: begin
        gnt_n_d = '1;
        if (bus_idle) state_d = S_IDLE;
      end

`ifdef PCI_ARB_PARK_EN
      S_PARK: begin
        if (!frame_n) begin
          owner_valid_d = 1'b1;
          ptr_d         = owner_q;
          state_d       = S_BUSY;
        end else if (|(~req_n & ~PARK_OH)) begin
          // Drop the park grant for one cycle before arbitrating for someone else
          gnt_n_d = '1;
          state_d = S_IDLE;
        end else if (!req_n[PARK_IDX]) begin
          timer_d = '0;
          state_d = S_GRANT;
        end
      end
`endif

      default: begin
        gnt_n_d       = '1;
        owner_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces every grant high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      ptr_q           <= PW'(N_MASTERS - 1);
      timer_q         <= '0;
      gnt_n_q         <= '1;
      owner_q         <= '0;
      owner_valid_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      timer_q         <= timer_d;
      gnt_n_q         <= gnt_n_d;
      owner_q         <= owner_d;
      owner_valid_q   <= owner_valid_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign gnt_n         = gnt_n_q;
  assign owner         = owner_q;
  assign owner_valid   = owner_valid_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// tb_pci_rr_arbiter: table-driven checks with a scoreboard queue, plus
// hand-written multi-cycle sequences for the arbiter corner cases.
module tb_pci_rr_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_n = '1;
  logic         frame_n = 1'b1;
  logic         irdy_n = 1'b1;
  logic [N-1:0] gnt_n;
  logic [2:0]   owner;
  logic         owner_valid;
  logic         timeout_pulse;

  pci_rr_arbiter #(.N_MASTERS(N), .GNT_TIMEOUT(16), .PARK_MASTER(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .gnt_n(gnt_n), .owner(owner), .owner_valid(owner_valid), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req_n;
    logic         frame_n;
    logic         irdy_n;
    logic [N-1:0] gnt_n;
    logic [2:0]   owner;
    logic         ov;
    logic         tp;
  } vec_t;

  vec_t         sb[$];
  vec_t         rr_tbl[30];
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] prev_gnt = '1;

`ifdef PCI_ARB_PARK_EN
  localparam logic [N-1:0] IDLE_GNT = 8'hFE;
`else
  localparam logic [N-1:0] IDLE_GNT = 8'hFF;
`endif

  function automatic vec_t mk(input logic [N-1:0] rq, input logic fr, input logic ir,
                              input logic [N-1:0] eg, input logic [2:0] ow,
                              input logic ov, input logic tp);
    vec_t v;
    v.req_n = rq; v.frame_n = fr; v.irdy_n = ir;
    v.gnt_n = eg; v.owner = ow; v.ov = ov; v.tp = tp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bus-wide invariants checked after every clock
  task automatic inv_checks();
    chk("gnt_onehot0", 32'($onehot0(~gnt_n)), 32'd1);
    chk("no_direct_handoff",
        32'(prev_gnt != '1 && gnt_n != '1 && prev_gnt != gnt_n), 32'd0);
    prev_gnt = gnt_n;
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge
  task automatic apply(input string nm, input vec_t v);
    vec_t e;
    req_n = v.req_n; frame_n = v.frame_n; irdy_n = v.irdy_n;
    sb.push_back(v);
    @(posedge clk); #1;
    inv_checks();
    e = sb.pop_front();
    chk({nm, ".gnt_n"}, 32'(gnt_n), 32'(e.gnt_n));
    chk({nm, ".owner"}, 32'(owner), 32'(e.owner));
    chk({nm, ".owner_valid"}, 32'(owner_valid), 32'(e.ov));
    chk({nm, ".timeout"}, 32'(timeout_pulse), 32'(e.tp));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
    sb.delete();
    prev_gnt = '1;
    @(posedge clk); #1;
    chk("rst.gnt_n", 32'(gnt_n), 32'hFF);
    chk("rst.owner", 32'(owner), 32'd0);
    chk("rst.owner_valid", 32'(owner_valid), 32'd0);
    chk("rst.timeout", 32'(timeout_pulse), 32'd0);
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 3, 0};

    // Round-robin table: each grantee runs a 3-cycle FRAME# transaction
    for (int s = 0; s < 5; s++) begin
      logic [N-1:0] g;
      logic [2:0]   m;
      m = 3'(seq[s]);
      g = ~(N'(1) << m);
      rr_tbl[s*6+0] = mk(8'hF0, 1'b1, 1'b1, g,     m, 1'b0, 1'b0);
      rr_tbl[s*6+1] = mk(8'hF0, 1'b0, 1'b1, g,     m, 1'b1, 1'b0);
      rr_tbl[s*6+2] = mk(8'hF0, 1'b0, 1'b0, g,     m, 1'b1, 1'b0);
      rr_tbl[s*6+3] = mk(8'hF0, 1'b0, 1'b0, g,     m, 1'b1, 1'b0);
      rr_tbl[s*6+4] = mk(8'hF0, 1'b1, 1'b0, 8'hFF, m, 1'b0, 1'b0);
      rr_tbl[s*6+5] = mk(8'hF0, 1'b1, 1'b1, 8'hFF, m, 1'b0, 1'b0);
    end

    // Idle after reset: no requests for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++)
      apply("idle", mk(8'hFF, 1'b1, 1'b1, IDLE_GNT, 3'd0, 1'b0, 1'b0));

    // Fair rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 30; i++) apply("rr", rr_tbl[i]);

    // Unused grant is revoked after 16 cycles; master 3 is granted next
    do_reset();
    for (int i = 0; i < 16; i++)
      apply("tmo_hold", mk(8'hF3, 1'b1, 1'b1, 8'hFB, 3'd2, 1'b0, 1'b0));
    apply("tmo_revoke", mk(8'hF3, 1'b1, 1'b1, 8'hFF, 3'd2, 1'b0, 1'b1));
    apply("tmo_next",   mk(8'hF3, 1'b1, 1'b1, 8'hF7, 3'd3, 1'b0, 1'b0));
    apply("tmo_wdraw",  mk(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b0));

    // Withdraw in GRANT, then a request dropped during BUSY is ignored
    do_reset();
    apply("wd_gnt",   mk(8'hFD, 1'b1, 1'b1, 8'hFD, 3'd1, 1'b0, 1'b0));
    apply("wd_drop",  mk(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd1, 1'b0, 1'b0));
    apply("bd_gnt",   mk(8'hFE, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0, 1'b0));
    apply("bd_busy0", mk(8'hFF, 1'b0, 1'b1, 8'hFE, 3'd0, 1'b1, 1'b0));
    apply("bd_busy1", mk(8'hFF, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b1, 1'b0));
    apply("bd_end",   mk(8'hFF, 1'b1, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
    apply("bd_turn",  mk(8'hFF, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));

    // Foreign transaction seen in IDLE: no grant until the bus is idle
    do_reset();
    apply("fg_frame0", mk(8'hFD, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
    apply("fg_frame1", mk(8'hFD, 1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
    apply("fg_last",   mk(8'hFD, 1'b1, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
    apply("fg_idle",   mk(8'hFD, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
    apply("fg_grant",  mk(8'hFD, 1'b1, 1'b1, 8'hFD, 3'd1, 1'b0, 1'b0));

    // Asynchronous reset in the middle of master 5's transaction
    do_reset();
    apply("mr_gnt",   mk(8'hDF, 1'b1, 1'b1, 8'hDF, 3'd5, 1'b0, 1'b0));
    apply("mr_busy0", mk(8'hDF, 1'b0, 1'b1, 8'hDF, 3'd5, 1'b1, 1'b0));
    apply("mr_busy1", mk(8'hDF, 1'b0, 1'b0, 8'hDF, 3'd5, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async.gnt_n", 32'(gnt_n), 32'hFF);
    chk("mr_async.owner_valid", 32'(owner_valid), 32'd0);
    chk("mr_async.owner", 32'(owner), 32'd0);
    req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
    prev_gnt = '1;
    @(negedge clk); rst_n = 1'b1;
    apply("mr_after", mk(8'hFF, 1'b1, 1'b1, IDLE_GNT, 3'd0, 1'b0, 1'b0));

`ifdef PCI_ARB_PARK_EN
    // Parking on master 0, then handing over to master 4
    do_reset();
    apply("pk_park0", mk(8'hFF, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0, 1'b0));
    apply("pk_park1", mk(8'hFF, 1'b1, 1'b1, 8'hFE, 3'd0, 1'b0, 1'b0));
    apply("pk_rel",   mk(8'hEF, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
    apply("pk_gnt4",  mk(8'hEF, 1'b1, 1'b1, 8'hEF, 3'd4, 1'b0, 1'b0));
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
